// File: rtl/sync_vg.sv
// Video timing generator: free-running line/frame counters decoded into
// registered sync, data-enable, read-request and active-pixel coordinates.
module sync_vg #(
    parameter int H_TOTAL   = 1892,
    parameter int H_SYNC    = 12,
    parameter int H_BP      = 300,
    parameter int H_ACT     = 1280,
    parameter int H_FP      = 300,
    parameter int V_TOTAL   = 740,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 9,
    parameter int V_ACT     = 720,
    parameter int V_FP      = 9,
    parameter int X_BITS    = 11,
    parameter int Y_BITS    = 10,
    parameter int HV_OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              vs_out,
    output logic              hs_out,
    output logic              de_out,
    output logic              de_re,
    output logic [X_BITS-1:0] x_act,
    output logic [Y_BITS-1:0] y_act
);

    // Counter widths follow the totals; one extra bit in the compare domain
    // keeps h_cnt+1 and the exclusive active-end bounds from overflowing.
    localparam int HC_W = $clog2(H_TOTAL);
    localparam int VC_W = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);
    localparam logic [HC_W-1:0] HV_OFF = HC_W'(HV_OFFSET);

    localparam logic [HC_W:0] HS_END = (HC_W+1)'(H_SYNC);
    localparam logic [HC_W:0] HA_STA = (HC_W+1)'(H_SYNC + H_BP);
    localparam logic [HC_W:0] HA_END = (HC_W+1)'(H_SYNC + H_BP + H_ACT);
    localparam logic [VC_W:0] VS_END = (VC_W+1)'(V_SYNC);
    localparam logic [VC_W:0] VA_STA = (VC_W+1)'(V_SYNC + V_BP);
    localparam logic [VC_W:0] VA_END = (VC_W+1)'(V_SYNC + V_BP + V_ACT);

    logic [HC_W-1:0] r_h_cnt;
    logic [VC_W-1:0] r_v_cnt;

    logic [HC_W:0]     w_h_ext;
    logic [HC_W:0]     w_h_nxt;
    logic [VC_W:0]     w_v_ext;
    logic              w_h_act;
    logic              w_h_act_nxt;
    logic              w_v_act;
    logic              w_de;
    logic              w_de_re;
    logic              w_hs;
    logic              w_vs;
    logic [HC_W:0]     w_x_off;
    logic [VC_W:0]     w_y_off;
    logic [X_BITS-1:0] w_x;
    logic [Y_BITS-1:0] w_y;

    assign w_h_ext     = {1'b0, r_h_cnt};
    assign w_h_nxt     = w_h_ext + (HC_W+1)'(1);
    assign w_v_ext     = {1'b0, r_v_cnt};

    assign w_h_act     = (w_h_ext >= HA_STA) && (w_h_ext < HA_END);
    assign w_h_act_nxt = (w_h_nxt >= HA_STA) && (w_h_nxt < HA_END);
    assign w_v_act     = (w_v_ext >= VA_STA) && (w_v_ext < VA_END);

    assign w_de        = w_h_act && w_v_act;
    // Look-ahead column, same row: sync width >= 1 means the look-ahead
    // never reaches the active area of the following line.
    assign w_de_re     = w_h_act_nxt && w_v_act;
    assign w_hs        = (w_h_ext < HS_END);
    assign w_vs        = (w_v_ext < VS_END);

    assign w_x_off     = w_h_ext - HA_STA;
    assign w_y_off     = w_v_ext - VA_STA;
    assign w_x         = X_BITS'(w_x_off);
    assign w_y         = Y_BITS'(w_y_off);

    // Horizontal counter wraps every line; vertical steps on the last column.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            if (r_v_cnt == V_LAST) begin
                r_v_cnt <= '0;
            end else begin
                r_v_cnt <= r_v_cnt + VC_W'(1);
            end
        end else begin
            r_h_cnt <= r_h_cnt + HC_W'(1);
        end
    end

    // Register the decode of the current counters; vsync moves only at the
    // chosen column so its edges sit at a fixed offset from the hsync edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            de_out <= 1'b0;
            de_re  <= 1'b0;
            x_act  <= '0;
            y_act  <= '0;
        end else begin
            hs_out <= w_hs;
            de_out <= w_de;
            de_re  <= w_de_re;
            x_act  <= w_de ? w_x : '0;
            y_act  <= w_de ? w_y : '0;
            if (r_h_cnt == HV_OFF) begin
                vs_out <= w_vs;
            end
        end
    end

endmodule

// File: tb/tb_sync_vg.sv
// Directed bench for sync_vg: two small-frame instances (vsync offset 0 and 3)
// checked cycle by cycle against hand-written line/row tables, and a
// default-size instance checked on line length, sync widths and active counts.
module tb_sync_vg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        a_vs, a_hs, a_de, a_dere;
    logic [10:0] a_x;
    logic [9:0]  a_y;
    logic        b_vs, b_hs, b_de, b_dere;
    logic [10:0] b_x;
    logic [9:0]  b_y;
    logic        d_vs, d_hs, d_de, d_dere;
    logic [10:0] d_x;
    logic [9:0]  d_y;

    sync_vg #(
        .H_TOTAL(10), .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
        .V_TOTAL(8),  .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(2),
        .X_BITS(11), .Y_BITS(10), .HV_OFFSET(0)
    ) u_a (
        .clk(clk), .rst(rst), .vs_out(a_vs), .hs_out(a_hs), .de_out(a_de),
        .de_re(a_dere), .x_act(a_x), .y_act(a_y)
    );

    sync_vg #(
        .H_TOTAL(10), .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2),
        .V_TOTAL(8),  .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(2),
        .X_BITS(11), .Y_BITS(10), .HV_OFFSET(3)
    ) u_b (
        .clk(clk), .rst(rst), .vs_out(b_vs), .hs_out(b_hs), .de_out(b_de),
        .de_re(b_dere), .x_act(b_x), .y_act(b_y)
    );

    sync_vg u_d (
        .clk(clk), .rst(rst), .vs_out(d_vs), .hs_out(d_hs), .de_out(d_de),
        .de_re(d_dere), .x_act(d_x), .y_act(d_y)
    );

    // Small-frame tables, bit/element index = column (h) or row (v).
    localparam bit [9:0] HS_COL   = 10'b0000000011;
    localparam bit [9:0] DE_COL   = 10'b0011110000;
    localparam bit [9:0] DERE_COL = 10'b0001111000;
    localparam bit [7:0] DE_ROW   = 8'b00111100;
    localparam bit [7:0] VS_ROW   = 8'b00000001;
    int x_col [10] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 0};
    int y_row [8]  = '{0, 0, 0, 1, 2, 3, 0, 0};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string ph);
        chk({ph, " a_vs"}, 32'(a_vs), 0);   chk({ph, " a_hs"}, 32'(a_hs), 0);
        chk({ph, " a_de"}, 32'(a_de), 0);   chk({ph, " a_dere"}, 32'(a_dere), 0);
        chk({ph, " a_x"}, 32'(a_x), 0);     chk({ph, " a_y"}, 32'(a_y), 0);
        chk({ph, " b_vs"}, 32'(b_vs), 0);   chk({ph, " b_hs"}, 32'(b_hs), 0);
        chk({ph, " d_vs"}, 32'(d_vs), 0);   chk({ph, " d_hs"}, 32'(d_hs), 0);
        chk({ph, " d_de"}, 32'(d_de), 0);   chk({ph, " d_dere"}, 32'(d_dere), 0);
    endtask

    // k = clocks since reset release minus one (k=0 is the first edge).
    task automatic check_small(input string ph, input int k);
        int  h, v, ex, ey, evs_b;
        bit  ede;
        string t;
        h   = k % 10;
        v   = (k / 10) % 8;
        ede = DE_COL[h] & DE_ROW[v];
        ex  = ede ? x_col[h] : 0;
        ey  = ede ? y_row[v] : 0;
        if (h >= 3)      evs_b = int'(VS_ROW[v]);
        else if (k < 3)  evs_b = 0;
        else             evs_b = int'(VS_ROW[(v + 7) % 8]);
        t = $sformatf("%s k=%0d", ph, k);
        chk({t, " hs"},   32'(a_hs),   32'(HS_COL[h]));
        chk({t, " vs"},   32'(a_vs),   32'(VS_ROW[v]));
        chk({t, " de"},   32'(a_de),   32'(ede));
        chk({t, " dere"}, 32'(a_dere), 32'(DERE_COL[h] & DE_ROW[v]));
        chk({t, " x"},    32'(a_x),    32'(ex));
        chk({t, " y"},    32'(a_y),    32'(ey));
        chk({t, " b_hs"}, 32'(b_hs),   32'(HS_COL[h]));
        chk({t, " b_vs"}, 32'(b_vs),   32'(evs_b));
        chk({t, " b_de"}, 32'(b_de),   32'(ede));
    endtask

    int hs0, de_pre, de_l11, de_l12, xmax, first_de, y11, y12, stray_x;
    int vs_a, vs_b, hs_a, hs_b;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");

        // Two full small frames after release.
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 160; k++) begin
            tick();
            check_small("run", k);
        end

        // Default-size instance: first 13 lines.
        @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks("rst2");
        @(negedge clk);
        rst = 1'b0;
        hs0 = 0; de_pre = 0; de_l11 = 0; de_l12 = 0; xmax = 0;
        first_de = -1; y11 = -1; y12 = -1; stray_x = 0;
        vs_a = 0; vs_b = 1; hs_a = 1; hs_b = 0;
        for (int k = 0; k < 13 * 1892; k++) begin
            int line;
            tick();
            line = k / 1892;
            if (line == 0 && d_hs) hs0++;
            if (k == 1891) hs_a = int'(d_hs);
            if (k == 1892) hs_b = int'(d_hs);
            if (k == 2 * 1892 - 1) vs_a = int'(d_vs);
            if (k == 2 * 1892) vs_b = int'(d_vs);
            if (d_de) begin
                if (line < 11) de_pre++;
                if (line == 11) begin
                    if (y11 < 0) y11 = int'(d_y);
                    de_l11++;
                end
                if (line == 12) begin
                    if (y12 < 0) y12 = int'(d_y);
                    de_l12++;
                end
                if (first_de < 0) first_de = k;
                if (int'(d_x) > xmax) xmax = int'(d_x);
            end else if (d_x != 0) begin
                stray_x++;
            end
        end
        chk("d hs width", 32'(hs0), 12);
        chk("d hs end of line", 32'(hs_a), 0);
        chk("d hs period", 32'(hs_b), 1);
        chk("d vs last sync line", 32'(vs_a), 1);
        chk("d vs drop", 32'(vs_b), 0);
        chk("d de before row 11", 32'(de_pre), 0);
        chk("d de first k", 32'(first_de), 11 * 1892 + 312);
        chk("d de line 11", 32'(de_l11), 1280);
        chk("d de line 12", 32'(de_l12), 1280);
        chk("d x max", 32'(xmax), 1279);
        chk("d y line 11", 32'(y11), 0);
        chk("d y line 12", 32'(y12), 1);
        chk("d x outside de", 32'(stray_x), 0);

        // Reset in the middle of an active line of the small frame.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            tick();
            check_small("pre", k);
        end
        chk("mid de active", 32'(a_de), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks("mid");
        repeat (2) tick();
        reset_checks("mid hold");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            check_small("post", k);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
